router_fsm: RTL and testbench



---
 rtl/router_fsm.sv | 145 ++++++++++++++
 tb/tb_router_fsm.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/router_fsm.sv
// Control FSM of the 1x3 router: header decode, payload/parity sequencing, full/empty stalls.
// Optional stall watchdog with pkt_drop pulse is built when ROUTER_FSM_TIMEOUT_EN is defined.
module router_fsm #(
    parameter int TIMEOUT_CYCLES = 30
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       write_enb_reg,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       busy,
    output logic       pkt_drop
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR,
        WAIT_TILL_EMPTY
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic [2:0] empty_vec;
    logic [2:0] srst_vec;
    logic       srst_abort;
    logic       stall;
    logic       timeout;

    // The watchdog counter needs at least one real compare value.
    if (TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("router_fsm: TIMEOUT_CYCLES must be at least 2");
    end

    assign empty_vec  = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign srst_vec   = {soft_reset_2, soft_reset_1, soft_reset_0};
    assign srst_abort = (state_q != DECODE_ADDRESS) && srst_vec[addr_q];
    assign stall      = (state_q == WAIT_TILL_EMPTY) || (state_q == FIFO_FULL_STATE);

`ifdef ROUTER_FSM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drop_q, drop_d;

    assign timeout  = stall && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign drop_d   = timeout && !srst_abort;
    assign pkt_drop = drop_q;
`else
    assign timeout  = 1'b0;
    assign pkt_drop = 1'b0;
`endif

    // NOTE: every always_comb target gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            DECODE_ADDRESS: begin
                if (pkt_valid && (data_in != 2'd3)) begin
                    addr_d  = data_in;
                    state_d = empty_vec[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        state_d = DECODE_ADDRESS;
                else if (low_pkt_valid) state_d = LOAD_PARITY;
                else                    state_d = LOAD_DATA;
            end
            LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY: begin
                if (empty_vec[addr_q]) state_d = LOAD_FIRST_DATA;
            end
            default: state_d = DECODE_ADDRESS;
        endcase
        // Soft reset of the selected port overrides everything, including the watchdog.
        if (timeout)    state_d = DECODE_ADDRESS;
        if (srst_abort) state_d = DECODE_ADDRESS;
    end

`ifdef ROUTER_FSM_TIMEOUT_EN
    always_comb begin
        cnt_d = '0;
        if (stall && (state_d == state_q)) cnt_d = cnt_q + 1'b1;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= 2'd0;
`ifdef ROUTER_FSM_TIMEOUT_EN
            cnt_q   <= '0;
            drop_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
`ifdef ROUTER_FSM_TIMEOUT_EN
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
`endif
        end
    end

    assign detect_add    = (state_q == DECODE_ADDRESS);
    assign lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign ld_state      = (state_q == LOAD_DATA);
    assign laf_state     = (state_q == LOAD_AFTER_FULL);
    assign full_state    = (state_q == FIFO_FULL_STATE);
    assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                           (state_q == LOAD_AFTER_FULL);
    assign busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: outputs are packed into one vector and compared
// against the expected Moore output pattern of each state.
module tb_router_fsm;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       write_enb_reg, detect_add, lfd_state, ld_state, laf_state;
    logic       full_state, rst_int_reg, busy, pkt_drop;

    int tests  = 0;
    int failed = 0;

    // {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy, pkt_drop}
    localparam logic [8:0] S_DA   = 9'b1_00000_0_0_0;
    localparam logic [8:0] S_LFD  = 9'b0_10000_0_1_0;
    localparam logic [8:0] S_LD   = 9'b0_01000_1_0_0;
    localparam logic [8:0] S_LAF  = 9'b0_00100_1_1_0;
    localparam logic [8:0] S_FFS  = 9'b0_00010_0_1_0;
    localparam logic [8:0] S_LP   = 9'b0_00000_1_1_0;
    localparam logic [8:0] S_CPE  = 9'b0_00001_0_1_0;
    localparam logic [8:0] S_WTE  = 9'b0_00000_0_1_0;
    localparam logic [8:0] S_DROP = 9'b1_00000_0_0_1;

    logic [8:0] outs;
    assign outs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                   rst_int_reg, write_enb_reg, busy, pkt_drop};

    router_fsm #(.TIMEOUT_CYCLES(30)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .write_enb_reg(write_enb_reg), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .busy(busy), .pkt_drop(pkt_drop)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    // Inputs change just after a falling edge; outputs are checked on the next falling edge.
    task automatic cyc();
        @(negedge clock);
    endtask

    initial begin
        resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        fifo_empty_0 = 1'b0; fifo_empty_1 = 1'b0; fifo_empty_2 = 1'b0;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        parity_done = 1'b0; low_pkt_valid = 1'b0;

        #3 check("reset", outs, S_DA);
        @(negedge clock);
        resetn = 1'b1;
        check("idle", outs, S_DA);

        // Good packet, header 8'h11: addr 1, 4 payload bytes
        data_in = 2'd1; fifo_empty_1 = 1'b1; pkt_valid = 1'b1;
        cyc(); check("good_lfd", outs, S_LFD);
        data_in = 2'd2;
        cyc(); check("good_ld1", outs, S_LD);
        cyc(); check("good_ld2", outs, S_LD);
        cyc(); check("good_ld3", outs, S_LD);
        cyc(); check("good_ld4", outs, S_LD);
        pkt_valid = 1'b0;
        cyc(); check("good_lp", outs, S_LP);
        cyc(); check("good_cpe", outs, S_CPE);
        cyc(); check("good_done", outs, S_DA);
        cyc(); check("good_idle", outs, S_DA);

        // Destination busy: addr 2 not empty for 7 cycles, fifo_empty_0 toggling
        data_in = 2'd2; fifo_empty_2 = 1'b0; pkt_valid = 1'b1;
        cyc();
        for (int i = 0; i < 7; i++) begin
            check("wte_hold", outs, S_WTE);
            fifo_empty_0 = ~fifo_empty_0;
            if (i == 6) fifo_empty_2 = 1'b1;
            cyc();
        end
        check("wte_release", outs, S_LFD);

        // Overflow during payload, released with low_pkt_valid
        cyc(); check("ovf_ld", outs, S_LD);
        fifo_full = 1'b1;
        cyc(); check("ovf_ffs1", outs, S_FFS);
        cyc(); check("ovf_ffs2", outs, S_FFS);
        cyc(); check("ovf_ffs3", outs, S_FFS);
        fifo_full = 1'b0; low_pkt_valid = 1'b1;
        cyc(); check("ovf_laf", outs, S_LAF);
        cyc(); check("ovf_lp", outs, S_LP);
        low_pkt_valid = 1'b0; pkt_valid = 1'b0;
        cyc(); check("ovf_cpe", outs, S_CPE);
        cyc(); check("ovf_done", outs, S_DA);

        // Overflow released with parity_done: straight back to decode
        data_in = 2'd0; fifo_empty_0 = 1'b1; pkt_valid = 1'b1;
        cyc(); check("pd_lfd", outs, S_LFD);
        cyc(); check("pd_ld", outs, S_LD);
        fifo_full = 1'b1;
        cyc(); check("pd_ffs", outs, S_FFS);
        fifo_full = 1'b0; parity_done = 1'b1;
        cyc(); check("pd_laf", outs, S_LAF);
        pkt_valid = 1'b0;
        cyc(); check("pd_done", outs, S_DA);
        parity_done = 1'b0;
        cyc(); check("pd_idle", outs, S_DA);

        // Invalid address 3 is never accepted
        data_in = 2'd3; pkt_valid = 1'b1;
        cyc(); check("inv_addr1", outs, S_DA);
        cyc(); check("inv_addr2", outs, S_DA);
        pkt_valid = 1'b0;

        // Soft reset: non-selected port ignored, selected port aborts
        data_in = 2'd1; pkt_valid = 1'b1;
        cyc(); check("sr_lfd", outs, S_LFD);
        cyc(); check("sr_ld", outs, S_LD);
        soft_reset_0 = 1'b1;
        cyc(); check("sr_other", outs, S_LD);
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b1;
        cyc(); check("sr_sel", outs, S_DA);
        soft_reset_1 = 1'b0; pkt_valid = 1'b0;
        cyc(); check("sr_idle", outs, S_DA);

        // Asynchronous reset mid-payload, observed before any clock edge
        data_in = 2'd1; pkt_valid = 1'b1;
        cyc(); check("ar_lfd", outs, S_LFD);
        cyc(); check("ar_ld", outs, S_LD);
        #2 resetn = 1'b0;
        #1 check("ar_async", outs, S_DA);
        pkt_valid = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        check("ar_held", outs, S_DA);

        // Stall watchdog on WAIT_TILL_EMPTY
        data_in = 2'd1; fifo_empty_1 = 1'b0; pkt_valid = 1'b1;
        cyc();
        pkt_valid = 1'b0;
`ifdef ROUTER_FSM_TIMEOUT_EN
        for (int i = 0; i < 30; i++) begin
            check("to_wait", outs, S_WTE);
            cyc();
        end
        check("to_drop", outs, S_DROP);
        cyc(); check("to_drop_end", outs, S_DA);
`else
        for (int i = 0; i < 40; i++) begin
            check("to_wait", outs, S_WTE);
            cyc();
        end
        soft_reset_1 = 1'b1;
        cyc(); check("to_sr_exit", outs, S_DA);
        soft_reset_1 = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
